// File: rtl/seq_bcd_converter_if.sv
// Handshake and result bundle for seq_bcd_converter.
// The blank mask exists only when BCD_BLANK_EN is defined.
interface seq_bcd_converter_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
`ifdef BCD_BLANK_EN
        , input blank
`endif
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
`ifdef BCD_BLANK_EN
        , output blank
`endif
    );
endinterface

// File: rtl/seq_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock, saturating at all 9s.
// Optional macro BCD_BLANK_EN adds a registered leading-zero blanking mask.
module bcd_dabble_digit (
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    logic [3:0] adj;
    // adjusted digit peaks at 12, so the 4-bit add never wraps
    assign adj  = (d >= 4'd5) ? d + 4'd3 : d;
    assign q    = {adj[2:0], cin};
    assign cout = adj[3];
endmodule

module seq_bcd_converter #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bcd_converter_if.slave   bus
);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;

    logic [BIN_W-1:0]          sreg;
    logic [DIGITS-1:0][3:0]    scr, scr_nx;
    logic [DIGITS:0]           carry;
    logic [CW-1:0]             cnt;
    logic                      ovf_pend, ovf_now, last;

    assign carry[0] = sreg[BIN_W-1];

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_dabble_digit u_dig (
            .d    (scr[k]),
            .cin  (carry[k]),
            .q    (scr_nx[k]),
            .cout (carry[k+1])
        );
    end

    assign last    = (state == SHIFT) && (cnt == CW'(1));
    assign ovf_now = ovf_pend | carry[DIGITS];
    assign bus.busy = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              zero_hi;

    // blank digit k when it and every digit above it are zero; units stay lit
    always_comb begin
        blank_nx = '0;
        zero_hi  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_hi     = zero_hi & (scr_nx[k] == 4'd0);
            blank_nx[k] = zero_hi & ~ovf_now;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       bus.blank <= '0;
        else if (last) bus.blank <= blank_nx;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg         <= '0;
            scr          <= '0;
            cnt          <= '0;
            ovf_pend     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd      <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    sreg     <= bus.bin;
                    scr      <= '0;
                    ovf_pend <= 1'b0;
                    cnt      <= CW'(BIN_W);
                end
            end else begin
                sreg     <= {sreg[BIN_W-2:0], 1'b0};
                scr      <= scr_nx;
                ovf_pend <= ovf_now;
                cnt      <= cnt - CW'(1);
                if (last) begin
                    bus.done     <= 1'b1;
                    bus.bcd      <= ovf_now ? {DIGITS{4'h9}} : scr_nx;
                    bus.overflow <= ovf_now;
                end
            end
        end
    end
endmodule
